// File: rtl/mem_rd_return_router_pkg.sv
// rtl/mem_rd_return_router_pkg.sv - shared widths and requester tag encoding
package mem_rd_return_router_pkg;

   localparam int ADDR_W_DEF = 15;
   localparam int DATA_W_DEF = 16;

   typedef enum logic {
      REQ_1 = 1'b0,
      REQ_2 = 1'b1
   } req_id_t;

   // One in-flight read: occupies a pipeline slot and remembers who asked.
   typedef struct packed {
      logic    valid;
      req_id_t id;
   } rd_tag_t;

endpackage

// File: rtl/mem_rd_return_router_arb.sv
// rtl/mem_rd_return_router_arb.sv - two-way round-robin arbiter, combinational grants
module rr_arb2
   import mem_rd_return_router_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic req1,
   input  logic req2,
   input  logic accept,
   output logic gnt1,
   output logic gnt2
);

   req_id_t ptr;

   // Grants are forced low during reset so nothing is accepted into a cleared pipeline.
   always_comb begin
      gnt1 = 1'b0;
      gnt2 = 1'b0;
      if (rst_n) begin
         if (req1 && (!req2 || ptr == REQ_1)) begin
            gnt1 = 1'b1;
         end else if (req2) begin
            gnt2 = 1'b1;
         end
      end
   end

   // After any accepted request priority passes to the requester that was not served.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= REQ_1;
      end else if (accept) begin
         ptr <= gnt2 ? REQ_1 : REQ_2;
      end
   end

endmodule

// File: rtl/mem_rd_return_router.sv
// rtl/mem_rd_return_router.sv - shares one BRAM read port between two requesters
module mem_rd_return_router
   import mem_rd_return_router_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_LAT = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req1,
   input  logic [ADDR_W-1:0] addr1,
   output logic              gnt1,
   output logic [DATA_W-1:0] rdata1,
   output logic              rvalid1,
   input  logic              req2,
   input  logic [ADDR_W-1:0] addr2,
   output logic              gnt2,
   output logic [DATA_W-1:0] rdata2,
   output logic              rvalid2,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_dout
);

   logic    accept;
   rd_tag_t tag_pipe [RD_LAT+1];

   assign accept = gnt1 | gnt2;

   rr_arb2 u_arb (
      .clk    (clk),
      .rst_n  (rst_n),
      .req1   (req1),
      .req2   (req2),
      .accept (accept),
      .gnt1   (gnt1),
      .gnt2   (gnt2)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_en   <= 1'b0;
         mem_addr <= '0;
      end else begin
         mem_en <= accept;
         if (accept) begin
            mem_addr <= gnt2 ? addr2 : addr1;
         end
      end
   end

   // Stage 0 lines up with mem_en; the last stage lines up with mem_dout being valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= RD_LAT; i++) begin
            tag_pipe[i] <= '0;
         end
      end else begin
         tag_pipe[0] <= '{valid: accept, id: (gnt2 ? REQ_2 : REQ_1)};
         for (int i = 1; i <= RD_LAT; i++) begin
            tag_pipe[i] <= tag_pipe[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid1 <= 1'b0;
         rvalid2 <= 1'b0;
         rdata1  <= '0;
         rdata2  <= '0;
      end else begin
         rvalid1 <= tag_pipe[RD_LAT].valid && (tag_pipe[RD_LAT].id == REQ_1);
         rvalid2 <= tag_pipe[RD_LAT].valid && (tag_pipe[RD_LAT].id == REQ_2);
         if (tag_pipe[RD_LAT].valid && tag_pipe[RD_LAT].id == REQ_1) begin
            rdata1 <= mem_dout;
         end
         if (tag_pipe[RD_LAT].valid && tag_pipe[RD_LAT].id == REQ_2) begin
            rdata2 <= mem_dout;
         end
      end
   end

endmodule

// File: doc/mem_rd_return_router.md
MEM_RD_RETURN_ROUTER -- requirements
Module: mem_rd_return_router

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W  15  memory address width
  DATA_W  16  memory data width
  RD_LAT  1   BRAM read latency in cycles (range 1..4)
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk       in   1       single clock; all logic on rising edge
  rst_n     in   1       asynchronous active-low reset
  req1      in   1       requester 1 read request
  addr1     in   ADDR_W  requester 1 read address
  gnt1      out  1       requester 1 request accepted this cycle
  rdata1    out  DATA_W  requester 1 read data
  rvalid1   out  1       rdata1 valid, 1-cycle pulse
  req2      in   1       requester 2 read request
  addr2     in   ADDR_W  requester 2 read address
  gnt2      out  1       requester 2 request accepted this cycle
  rdata2    out  DATA_W  requester 2 read data
  rvalid2   out  1       rdata2 valid, 1-cycle pulse
  mem_en    out  1       BRAM port enable (registered)
  mem_addr  out  ADDR_W  BRAM port address (registered)
  mem_dout  in   DATA_W  BRAM read data
REQ-003 The block SHALL have one clock, clk; reset SHALL be asynchronous and active-low on rst_n.

Function
REQ-004 gnt1/gnt2 SHALL be combinational from req1, req2 and the priority pointer; at most one SHALL be high per cycle.
REQ-005 A request SHALL be accepted in cycle N iff reqX and gntX are both high in N; a requester SHALL hold reqX/addrX until granted.
REQ-006 Only one requester active: its gnt SHALL be high in the same cycle.
REQ-007 Both active: the priority holder SHALL be granted; the pointer SHALL then move to the other requester (round-robin).
REQ-008 The pointer SHALL change only on an accepted request.
REQ-009 On accept in cycle N: mem_en=1 and mem_addr=granted address in cycle N+1; otherwise mem_en=0 and mem_addr holds its last value.
REQ-010 mem_dout SHALL be sampled in cycle N+1+RD_LAT; rdataX/rvalidX SHALL be registered, making rvalidX high in cycle N+2+RD_LAT.
REQ-011 Fixed accept-to-rvalid latency: RD_LAT+2 cycles.
REQ-012 Returns SHALL follow request order.
REQ-013 Each in-flight read SHALL carry a tag (valid bit + requester id) through an RD_LAT+1-deep shift pipeline.
REQ-014 Throughput SHALL be one accepted read per cycle, no stalls or bubbles.
REQ-015 rvalid1 and rvalid2 SHALL never be high in the same cycle.
REQ-016 rdataX SHALL update only when rvalidX is high and hold otherwise.
REQ-017 The block SHALL have no backpressure on returns: requesters SHALL accept rvalid in the cycle it occurs.

Reset
REQ-018 With rst_n low: priority pointer=requester 1; mem_en=0; mem_addr=0; rdata1=rdata2=0; rvalid1=rvalid2=0; all tags invalid.
REQ-019 gnt1/gnt2 SHALL be 0 while rst_n is low.
REQ-020 Reset asserted mid-operation SHALL discard in-flight reads: no rvalid for any read accepted before reset.
REQ-021 The first request SHALL be accepted in the first cycle after rst_n deasserts.

Structure
REQ-022 A shared package SHALL hold ADDR_W/DATA_W defaults and the requester-id tag encoding (REQ_1=0, REQ_2=1).
REQ-023 Arbitration SHALL live in one sub-module, rr_arb2: req1, req2, accept -> gnt1, gnt2, pointer register.
REQ-024 Tag pipeline, address register and return registers SHALL stay in the top module.

Verification
REQ-025 RD_LAT=1, req1 only, addr1=0x0010, BRAM returns 0xBEEF: gnt1 same cycle; mem_en/mem_addr=0x0010 one cycle later; rvalid1 with rdata1=0xBEEF 3 cycles after accept; rvalid2 stays 0.
REQ-026 req1 and req2 held together for 4 cycles after reset, addr1=0x0001, addr2=0x0002: grants 1,2,1,2; rvalid pulses 1,2,1,2 back to back; rdata matches each address.
REQ-027 req2 held continuously, req1 raised in cycle 3: round-robin gives req1 the next grant; no cycle with both gnts high.
REQ-028 RD_LAT=3, 8 back-to-back reads: 8 consecutive rvalid pulses, first one 5 cycles after first accept, order preserved.
REQ-029 rst_n asserted 1 cycle after two accepts, then released: no rvalid ever occurs for those reads; all outputs 0; pointer=requester 1.
REQ-030 Idle for 10 cycles after a read: rdata1 holds its last value; mem_en=0; mem_addr unchanged.
